// File: rtl/rename_pkg.sv
// Shared types and helpers for the rename/dispatch queue: entry layout,
// operand formation and CDB tag matching.
package rename_pkg;

    localparam int XLEN    = 32;
    localparam int ROBID_W = 8;
    localparam int RSOP_W  = 5;
    localparam int RD_W    = 6;

    typedef enum logic [1:0] {
        CLS_EXE,
        CLS_LSQ,
        CLS_CSR
    } dq_class_e;

    typedef struct packed {
        logic            ready;
        logic [XLEN-1:0] value;
    } dq_opnd_t;

    typedef struct packed {
        dq_opnd_t op1;
        dq_opnd_t op2;
    } dq_opnd_pair_t;

    typedef struct packed {
        logic [RSOP_W-1:0]  op;
        logic [ROBID_W-1:0] robid;
        logic [RD_W-1:0]    rd;
        logic               store;
        dq_class_e          cls;
        logic [XLEN-1:0]    imm;
    } dq_meta_t;

    typedef struct packed {
        dq_meta_t meta;
        dq_opnd_t op1;
        dq_opnd_t op2;
    } dq_entry_t;

    // A waiting operand picks up a matching broadcast; ready operands are left alone.
    function automatic dq_opnd_t cdb_forward(dq_opnd_t o, logic cdb_valid,
                                             logic [ROBID_W-1:0] cdb_tag,
                                             logic [XLEN-1:0] cdb_value);
        dq_opnd_t r;
        r = o;
        if (!o.ready && cdb_valid && (o.value[ROBID_W-1:0] == cdb_tag)) begin
            r.ready = 1'b1;
            r.value = cdb_value;
        end
        return r;
    endfunction

    function automatic dq_opnd_pair_t form_operands(
        logic uses_rs1, logic uses_pc, logic uses_rs2, logic uses_imm,
        logic [XLEN-3:0] addr, logic [XLEN-1:0] imm,
        logic rs1_valid, logic [XLEN-1:0] rs1_tagval,
        logic rs2_valid, logic [XLEN-1:0] rs2_tagval);
        dq_opnd_pair_t r;
        r.op1 = '{ready: 1'b1, value: '0};
        r.op2 = '{ready: 1'b1, value: '0};
        case ({uses_rs1, uses_pc})
            2'b00: r.op1 = '{ready: 1'b1, value: imm};
            2'b01: begin
                r.op1 = '{ready: 1'b1, value: {addr, 2'b00}};
                r.op2 = '{ready: 1'b1, value: imm};
            end
            2'b10: begin
                r.op1 = '{ready: rs1_valid, value: rs1_tagval};
                if (uses_rs2)
                    r.op2 = '{ready: rs2_valid, value: rs2_tagval};
                else if (uses_imm)
                    r.op2 = '{ready: 1'b1, value: imm};
            end
            default: ;
        endcase
        return r;
    endfunction

    function automatic dq_class_e classify(logic uses_memory, logic csr_access);
        if (uses_memory)
            return CLS_LSQ;
        else if (csr_access)
            return CLS_CSR;
        return CLS_EXE;
    endfunction

    function automatic logic class_stalled(dq_class_e c, logic exe_stall,
                                           logic lsq_stall, logic csr_stall);
        case (c)
            CLS_LSQ: return lsq_stall;
            CLS_CSR: return csr_stall;
            default: return exe_stall;
        endcase
    endfunction

endpackage

// File: rtl/rename_dispatch_q_if.sv
// Decode / RAT / CDB / reservation-station bundle seen by the rename queue.
interface rename_dispatch_q_if #(
    parameter int DEPTH = 4
);
    import rename_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                decode_rename_valid;
    logic [XLEN-3:0]     decode_addr;
    logic [RSOP_W-1:0]   decode_rsop;
    logic [ROBID_W-1:0]  decode_robid;
    logic [RD_W-1:0]     decode_rd;
    logic                decode_uses_rs1, decode_uses_rs2, decode_uses_imm;
    logic                decode_uses_memory, decode_uses_pc, decode_store, decode_csr_access;
    logic [4:0]          decode_rs1, decode_rs2;
    logic [XLEN-1:0]     decode_imm;
    logic                rename_stall;
    logic                rename_rat_valid;
    logic [RD_W-1:0]     rename_rat_rd;
    logic [ROBID_W-1:0]  rename_rat_robid;
    logic [4:0]          rename_rat_rs1, rename_rat_rs2;
    logic                rat_rs1_valid, rat_rs2_valid;
    logic [XLEN-1:0]     rat_rs1_tagval, rat_rs2_tagval;
    logic                cdb_valid;
    logic [ROBID_W-1:0]  cdb_tag;
    logic [XLEN-1:0]     cdb_value;
    logic                rename_exers_write, rename_lsq_write, rename_csr_write;
    logic [RSOP_W-1:0]   rename_op;
    logic [ROBID_W-1:0]  rename_robid;
    logic [RD_W-1:0]     rename_rd;
    logic [XLEN-1:0]     rename_imm;
    logic                rename_store;
    logic                rename_op1ready, rename_op2ready;
    logic [XLEN-1:0]     rename_op1, rename_op2;
    logic                exers_stall, lsq_stall, csr_stall;
    logic                rob_flush;
    logic [CNT_W-1:0]    dq_count;

    modport slave (
        input  decode_rename_valid, decode_addr, decode_rsop, decode_robid, decode_rd,
               decode_uses_rs1, decode_uses_rs2, decode_uses_imm, decode_uses_memory,
               decode_uses_pc, decode_store, decode_csr_access, decode_rs1, decode_rs2,
               decode_imm, rat_rs1_valid, rat_rs2_valid, rat_rs1_tagval, rat_rs2_tagval,
               cdb_valid, cdb_tag, cdb_value, exers_stall, lsq_stall, csr_stall, rob_flush,
        output rename_stall, rename_rat_valid, rename_rat_rd, rename_rat_robid,
               rename_rat_rs1, rename_rat_rs2, rename_exers_write, rename_lsq_write,
               rename_csr_write, rename_op, rename_robid, rename_rd, rename_imm, rename_store,
               rename_op1ready, rename_op1, rename_op2ready, rename_op2, dq_count
    );

    modport master (
        output decode_rename_valid, decode_addr, decode_rsop, decode_robid, decode_rd,
               decode_uses_rs1, decode_uses_rs2, decode_uses_imm, decode_uses_memory,
               decode_uses_pc, decode_store, decode_csr_access, decode_rs1, decode_rs2,
               decode_imm, rat_rs1_valid, rat_rs2_valid, rat_rs1_tagval, rat_rs2_tagval,
               cdb_valid, cdb_tag, cdb_value, exers_stall, lsq_stall, csr_stall, rob_flush,
        input  rename_stall, rename_rat_valid, rename_rat_rd, rename_rat_robid,
               rename_rat_rs1, rename_rat_rs2, rename_exers_write, rename_lsq_write,
               rename_csr_write, rename_op, rename_robid, rename_rd, rename_imm, rename_store,
               rename_op1ready, rename_op1, rename_op2ready, rename_op2, dq_count
    );

endinterface

// File: rtl/dq_operand_slot.sv
// One buffered operand: ready/value register that loads at enqueue and
// wakes up on a matching CDB broadcast.
module dq_operand_slot
    import rename_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  dq_opnd_t           load_opnd_i,
    input  logic               cdb_valid_i,
    input  logic [ROBID_W-1:0] cdb_tag_i,
    input  logic [XLEN-1:0]    cdb_value_i,
    output dq_opnd_t           opnd_o
);

    dq_opnd_t opnd_q, opnd_d;

    // Loading also snoops, so a broadcast in the accept cycle is not missed.
    always_comb begin
        if (load_i)
            opnd_d = cdb_forward(load_opnd_i, cdb_valid_i, cdb_tag_i, cdb_value_i);
        else
            opnd_d = cdb_forward(opnd_q, cdb_valid_i, cdb_tag_i, cdb_value_i);
    end

    always_ff @(posedge clk) begin
        if (rst)
            opnd_q <= '0;
        else
            opnd_q <= opnd_d;
    end

    assign opnd_o = opnd_q;

endmodule

// File: rtl/rename_dispatch_q.sv
// Rename stage with a DEPTH-entry in-order dispatch queue and CDB wakeup.
// Optional same-cycle dispatch into an empty queue: define DISPATCH_BYPASS_EN.
module rename_dispatch_q
    import rename_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    rename_dispatch_q_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    dq_meta_t         meta_q [DEPTH];
    dq_opnd_t         op1_slot [DEPTH];
    dq_opnd_t         op2_slot [DEPTH];
    dq_opnd_pair_t    formed;
    dq_meta_t         in_meta;
    dq_entry_t        head, disp_entry;
    logic             full, accept, enq, dispatch, pop;

    // Stall depends on occupancy only, never on the channel stalls.
    assign full   = (count_q == CNT_W'(DEPTH));
    assign accept = bus.decode_rename_valid && !full && !bus.rob_flush && !rst;

    assign formed = form_operands(bus.decode_uses_rs1, bus.decode_uses_pc,
                                  bus.decode_uses_rs2, bus.decode_uses_imm,
                                  bus.decode_addr, bus.decode_imm,
                                  bus.rat_rs1_valid, bus.rat_rs1_tagval,
                                  bus.rat_rs2_valid, bus.rat_rs2_tagval);

    always_comb begin
        in_meta.op    = bus.decode_rsop;
        in_meta.robid = bus.decode_robid;
        in_meta.rd    = bus.decode_rd;
        in_meta.store = bus.decode_store;
        in_meta.cls   = classify(bus.decode_uses_memory, bus.decode_csr_access);
        in_meta.imm   = bus.decode_imm;
    end

    always_comb begin
        head.meta = meta_q[rd_ptr_q];
        head.op1  = cdb_forward(op1_slot[rd_ptr_q], bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
        head.op2  = cdb_forward(op2_slot[rd_ptr_q], bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
    end

    always_comb begin
        disp_entry = head;
        dispatch   = (count_q != '0) && !bus.rob_flush && !rst &&
                     !class_stalled(head.meta.cls, bus.exers_stall, bus.lsq_stall, bus.csr_stall);
        enq        = accept;
`ifdef DISPATCH_BYPASS_EN
        if ((count_q == '0) && accept &&
            !class_stalled(in_meta.cls, bus.exers_stall, bus.lsq_stall, bus.csr_stall)) begin
            disp_entry = '{meta: in_meta,
                           op1: cdb_forward(formed.op1, bus.cdb_valid, bus.cdb_tag, bus.cdb_value),
                           op2: cdb_forward(formed.op2, bus.cdb_valid, bus.cdb_tag, bus.cdb_value)};
            dispatch   = 1'b1;
            enq        = 1'b0;
        end
`endif
    end

    assign pop = dispatch && (count_q != '0);

    always_comb begin
        if (bus.rob_flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            count_d  = count_q + CNT_W'(enq) - CNT_W'(pop);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            wr_ptr_d = wr_ptr_q + PTR_W'(enq);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Payload storage needs no reset: validity is carried by count and pointers.
    always_ff @(posedge clk) begin
        if (enq)
            meta_q[wr_ptr_q] <= in_meta;
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic load;
            assign load = enq && (wr_ptr_q == PTR_W'(gi));

            dq_operand_slot u_op1 (
                .clk         (clk),
                .rst         (rst),
                .load_i      (load),
                .load_opnd_i (formed.op1),
                .cdb_valid_i (bus.cdb_valid),
                .cdb_tag_i   (bus.cdb_tag),
                .cdb_value_i (bus.cdb_value),
                .opnd_o      (op1_slot[gi])
            );

            dq_operand_slot u_op2 (
                .clk         (clk),
                .rst         (rst),
                .load_i      (load),
                .load_opnd_i (formed.op2),
                .cdb_valid_i (bus.cdb_valid),
                .cdb_tag_i   (bus.cdb_tag),
                .cdb_value_i (bus.cdb_value),
                .opnd_o      (op2_slot[gi])
            );
        end
    endgenerate

    assign bus.rename_stall       = full;
    assign bus.rename_rat_valid   = accept;
    assign bus.rename_rat_rd      = bus.decode_rd;
    assign bus.rename_rat_robid   = bus.decode_robid;
    assign bus.rename_rat_rs1     = bus.decode_rs1;
    assign bus.rename_rat_rs2     = bus.decode_rs2;

    assign bus.rename_exers_write = dispatch && (disp_entry.meta.cls == CLS_EXE);
    assign bus.rename_lsq_write   = dispatch && (disp_entry.meta.cls == CLS_LSQ);
    assign bus.rename_csr_write   = dispatch && (disp_entry.meta.cls == CLS_CSR);

    assign bus.rename_op          = disp_entry.meta.op;
    assign bus.rename_robid       = disp_entry.meta.robid;
    assign bus.rename_rd          = disp_entry.meta.rd;
    assign bus.rename_imm         = disp_entry.meta.imm;
    assign bus.rename_store       = disp_entry.meta.store;
    assign bus.rename_op1ready    = disp_entry.op1.ready;
    assign bus.rename_op1         = disp_entry.op1.value;
    assign bus.rename_op2ready    = disp_entry.op2.ready;
    assign bus.rename_op2         = disp_entry.op2.value;
    assign bus.dq_count           = count_q;

endmodule

// File: tb/tb_rename_dispatch_q.sv
// Randomized and directed bench for rename_dispatch_q against a queue-based
// reference model of the rename/dispatch rules.
module tb_rename_dispatch_q;

    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  op;
        logic [7:0]  robid;
        logic [5:0]  rd;
        logic        store;
        int          cls;      // 0 exe, 1 lsq, 2 csr
        logic [31:0] imm;
        logic        r1;
        logic [31:0] v1;
        logic        r2;
        logic [31:0] v2;
    } item_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    item_t mq[$];
    logic [7:0] robid_ctr = 8'h00;

    rename_dispatch_q_if #(.DEPTH(DEPTH)) bus ();

    rename_dispatch_q #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void snoop(inout logic r, inout logic [31:0] v);
        if (!r && bus.cdb_valid && (v[7:0] == bus.cdb_tag)) begin
            r = 1'b1;
            v = bus.cdb_value;
        end
    endfunction

    function automatic logic stalled(input int cls);
        if (cls == 1) return bus.lsq_stall;
        if (cls == 2) return bus.csr_stall;
        return bus.exers_stall;
    endfunction

    function automatic item_t form_item();
        item_t it;
        it.op = bus.decode_rsop;  it.robid = bus.decode_robid;
        it.rd = bus.decode_rd;    it.store = bus.decode_store;
        it.imm = bus.decode_imm;
        it.cls = bus.decode_uses_memory ? 1 : (bus.decode_csr_access ? 2 : 0);
        it.r1 = 1'b1; it.v1 = 32'h0; it.r2 = 1'b1; it.v2 = 32'h0;
        if (!bus.decode_uses_rs1 && !bus.decode_uses_pc) begin
            it.v1 = bus.decode_imm;
        end else if (!bus.decode_uses_rs1 && bus.decode_uses_pc) begin
            it.v1 = {bus.decode_addr, 2'b00};
            it.v2 = bus.decode_imm;
        end else if (bus.decode_uses_rs1 && !bus.decode_uses_pc) begin
            it.r1 = bus.rat_rs1_valid; it.v1 = bus.rat_rs1_tagval;
            if (bus.decode_uses_rs2) begin
                it.r2 = bus.rat_rs2_valid; it.v2 = bus.rat_rs2_tagval;
            end else if (bus.decode_uses_imm) begin
                it.v2 = bus.decode_imm;
            end
        end
        snoop(it.r1, it.v1);
        snoop(it.r2, it.v2);
        return it;
    endfunction

    // Check this cycle's outputs against the model, then advance the model.
    task automatic model_step();
        item_t d, inc, t;
        logic  full, acc, disp, bypassed;
        full = (mq.size() == DEPTH);
        acc  = bus.decode_rename_valid && !full && !bus.rob_flush && !rst;
        disp = 1'b0; bypassed = 1'b0;
        inc  = form_item();
        d    = inc;
        if (mq.size() != 0 && !bus.rob_flush && !rst && !stalled(mq[0].cls)) begin
            disp = 1'b1;
            d = mq[0];
            snoop(d.r1, d.v1);
            snoop(d.r2, d.v2);
        end
`ifdef DISPATCH_BYPASS_EN
        if (mq.size() == 0 && acc && !stalled(inc.cls)) begin
            disp = 1'b1; bypassed = 1'b1; d = inc;
        end
`endif
        if (!rst) begin
            check_val("rename_stall", bus.rename_stall, full);
            check_val("rat_valid", bus.rename_rat_valid, acc);
            check_val("dq_count", bus.dq_count, mq.size());
            check_val("strobes {lsq,csr,exe}",
                      {bus.rename_lsq_write, bus.rename_csr_write, bus.rename_exers_write},
                      {disp && d.cls == 1, disp && d.cls == 2, disp && d.cls == 0});
            if (disp) begin
                check_val("head robid", bus.rename_robid, d.robid);
                check_val("head op/rd/store", {bus.rename_op, bus.rename_rd, bus.rename_store},
                          {d.op, d.rd, d.store});
                check_val("head imm", bus.rename_imm, d.imm);
                check_val("head op1", {bus.rename_op1ready, bus.rename_op1}, {d.r1, d.v1});
                check_val("head op2", {bus.rename_op2ready, bus.rename_op2}, {d.r2, d.v2});
            end
        end
        if (rst || bus.rob_flush) begin
            mq.delete();
        end else begin
            for (int i = 0; i < mq.size(); i++) begin
                t = mq[i];
                snoop(t.r1, t.v1);
                snoop(t.r2, t.v2);
                mq[i] = t;
            end
            if (disp && !bypassed) void'(mq.pop_front());
            if (acc && !bypassed) mq.push_back(inc);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.decode_rename_valid = 0; bus.decode_addr = '0; bus.decode_rsop = '0;
        bus.decode_robid = '0; bus.decode_rd = '0; bus.decode_uses_rs1 = 0;
        bus.decode_uses_rs2 = 0; bus.decode_uses_imm = 0; bus.decode_uses_memory = 0;
        bus.decode_uses_pc = 0; bus.decode_store = 0; bus.decode_csr_access = 0;
        bus.decode_rs1 = '0; bus.decode_rs2 = '0; bus.decode_imm = '0;
        bus.rat_rs1_valid = 0; bus.rat_rs2_valid = 0; bus.rat_rs1_tagval = '0;
        bus.rat_rs2_tagval = '0; bus.cdb_valid = 0; bus.cdb_tag = '0; bus.cdb_value = '0;
        bus.exers_stall = 0; bus.lsq_stall = 0; bus.csr_stall = 0; bus.rob_flush = 0;
    endtask

    // Register-register op: rs1 ready with value v1, rs2 waiting on tag2.
    task automatic send_add(input logic [7:0] robid, input logic [31:0] v1, input logic [7:0] tag2);
        bus.decode_rename_valid = 1; bus.decode_robid = robid;
        bus.decode_uses_rs1 = 1; bus.decode_uses_rs2 = 1; bus.decode_uses_imm = 0;
        bus.decode_uses_pc = 0; bus.decode_uses_memory = 0; bus.decode_csr_access = 0;
        bus.rat_rs1_valid = 1; bus.rat_rs1_tagval = v1;
        bus.rat_rs2_valid = 0; bus.rat_rs2_tagval = {24'h0, tag2};
    endtask

    task automatic drive_random(input int p_valid, input int p_stall, input int p_flush);
        int kind;
        logic [31:0] r;
        kind = int'($urandom_range(0, 4));
        bus.decode_rename_valid = ($urandom_range(0, 99) < p_valid);
        bus.decode_robid = robid_ctr; robid_ctr = robid_ctr + 8'd1;
        r = $urandom(); bus.decode_rsop = r[4:0]; bus.decode_rd = r[10:5];
        bus.decode_rs1 = r[15:11]; bus.decode_rs2 = r[20:16]; bus.decode_store = r[21];
        bus.decode_addr = 30'($urandom());
        bus.decode_imm  = $urandom();
        bus.decode_uses_rs1 = (kind >= 2);
        bus.decode_uses_pc  = (kind == 1) || (kind == 4);
        bus.decode_uses_rs2 = (kind == 2);
        bus.decode_uses_imm = (kind == 3) || (kind < 2);
        bus.decode_uses_memory = ($urandom_range(0, 99) < 25);
        bus.decode_csr_access  = ($urandom_range(0, 99) < 20);
        bus.rat_rs1_valid = $urandom_range(0, 1);
        bus.rat_rs2_valid = $urandom_range(0, 1);
        bus.rat_rs1_tagval = bus.rat_rs1_valid ? $urandom()
                           : (($urandom() & 32'hFFFF_FF00) | 32'($urandom_range(16, 23)));
        bus.rat_rs2_tagval = bus.rat_rs2_valid ? $urandom()
                           : (($urandom() & 32'hFFFF_FF00) | 32'($urandom_range(16, 23)));
        bus.cdb_valid = ($urandom_range(0, 99) < 40);
        bus.cdb_tag   = 8'($urandom_range(16, 23));
        bus.cdb_value = $urandom();
        bus.exers_stall = ($urandom_range(0, 99) < p_stall);
        bus.lsq_stall   = ($urandom_range(0, 99) < p_stall);
        bus.csr_stall   = ($urandom_range(0, 99) < p_stall);
        bus.rob_flush   = ($urandom_range(0, 999) < p_flush);
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        cycle(); cycle();
        rst = 0;
        #1;
        check_val("reset dq_count", bus.dq_count, 0);
        check_val("reset rename_stall", bus.rename_stall, 0);
        check_val("reset strobes", {bus.rename_exers_write, bus.rename_lsq_write, bus.rename_csr_write}, 0);

        // Basic ADD, one cycle to strobe.
        send_add(8'h40, 32'd5, 8'h12);
        cycle(); clear_inputs(); #1;
        check_val("add exers_write", bus.rename_exers_write, 1);
        check_val("add op1", {bus.rename_op1ready, bus.rename_op1}, {1'b1, 32'd5});
        check_val("add op2 tag", {bus.rename_op2ready, bus.rename_op2[7:0]}, {1'b0, 8'h12});
        cycle();

        // Wakeup while held, then wakeup forwarded in the fire cycle.
        bus.exers_stall = 1; send_add(8'h41, 32'd5, 8'h12);
        cycle(); bus.decode_rename_valid = 0;
        bus.cdb_valid = 1; bus.cdb_tag = 8'h12; bus.cdb_value = 32'hAB;
        cycle(); bus.cdb_valid = 0; bus.exers_stall = 0; #1;
        check_val("wakeup op2", {bus.rename_op2ready, bus.rename_op2}, {1'b1, 32'hAB});
        cycle();
        bus.exers_stall = 1; send_add(8'h42, 32'd5, 8'h12);
        cycle(); bus.decode_rename_valid = 0; bus.exers_stall = 0;
        bus.cdb_valid = 1; bus.cdb_tag = 8'h12; bus.cdb_value = 32'hCD; #1;
        check_val("forward op2", {bus.rename_exers_write, bus.rename_op2ready, bus.rename_op2},
                  {1'b1, 1'b1, 32'hCD});
        cycle(); clear_inputs();

        // Fill under lsq_stall, reject a fifth, drain in order.
        bus.lsq_stall = 1;
        for (int i = 0; i < 4; i++) begin
            bus.decode_rename_valid = 1; bus.decode_uses_memory = 1; bus.decode_uses_rs1 = 1;
            bus.decode_uses_imm = 1; bus.rat_rs1_valid = 1; bus.decode_robid = 8'h50 + 8'(i);
            cycle();
        end
        bus.decode_robid = 8'h54; #1;
        check_val("full stall/count", {bus.rename_stall, bus.dq_count}, {1'b1, 3'd4});
        check_val("full rat_valid", bus.rename_rat_valid, 0);
        cycle(); bus.decode_rename_valid = 0; bus.lsq_stall = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_val("drain lsq order", {bus.rename_lsq_write, bus.rename_robid}, {1'b1, 8'h50 + 8'(i)});
            cycle();
        end

        // Flush with three queued and an incoming instruction.
        bus.lsq_stall = 1; bus.decode_rename_valid = 1;
        for (int i = 0; i < 3; i++) cycle();
        bus.lsq_stall = 0; bus.rob_flush = 1; #1;
        check_val("flush strobes/rat", {bus.rename_lsq_write, bus.rename_rat_valid}, 0);
        cycle(); clear_inputs(); #1;
        check_val("flush dq_count", bus.dq_count, 0);

        // AUIPC operands.
        bus.decode_rename_valid = 1; bus.decode_uses_pc = 1; bus.decode_addr = 30'h400;
        bus.decode_imm = 32'h20; bus.decode_robid = 8'h5F;
        cycle(); clear_inputs(); #1;
        check_val("auipc ops", {bus.rename_op1ready, bus.rename_op1, bus.rename_op2ready, bus.rename_op2},
                  {1'b1, 32'h1000, 1'b1, 32'h20});
        cycle();

        // CSR head under csr_stall blocks a younger EXE op.
        bus.csr_stall = 1; bus.decode_rename_valid = 1; bus.decode_csr_access = 1; bus.decode_robid = 8'h60;
        cycle(); bus.decode_csr_access = 0; bus.decode_robid = 8'h61;
        cycle(); bus.decode_rename_valid = 0;
        cycle(); #1;
        check_val("csr blocks exe", {bus.rename_exers_write, bus.dq_count}, {1'b0, 3'd2});
        bus.csr_stall = 0; #1;
        check_val("csr release", {bus.rename_csr_write, bus.rename_robid}, {1'b1, 8'h60});
        cycle(); #1;
        check_val("exe after csr", {bus.rename_exers_write, bus.rename_robid}, {1'b1, 8'h61});
        cycle();

        // Steady enqueue+dispatch across pointer wrap.
        bus.exers_stall = 1; bus.decode_rename_valid = 1;
        for (int i = 0; i < 2; i++) begin bus.decode_robid = 8'h70 + 8'(i); cycle(); end
        bus.exers_stall = 0;
        for (int i = 0; i < 12; i++) begin
            bus.decode_robid = 8'h72 + 8'(i); #1;
            check_val("steady dq_count", bus.dq_count, 2);
            cycle();
        end
        clear_inputs();
        for (int i = 0; i < 4; i++) cycle();

        // Random phases with varying back-pressure.
        for (int i = 0; i < 800; i++) begin drive_random(70, 20, 5);  cycle(); end
        for (int i = 0; i < 800; i++) begin drive_random(90, 60, 10); cycle(); end
        for (int i = 0; i < 800; i++) begin drive_random(40, 5, 0);   cycle(); end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
